axis_frame_sink: RTL

AXI4-Stream slave that terminates the conware output stream (`M_AXIS_*`) and rebuilds each frame of colour words into a WIDTH-bit cell-state vector. Checks every frame for framing and colour errors, keeps beat and frame statistics, and applies a programmable backpressure pattern on TREADY. Used as the bench/SoC-side receiver that closes the stream loop for board readback and throughput tests.

---
 rtl/conware_pkg.sv | 26 ++
 rtl/axis_frame_sink_if.sv | 19 +
 rtl/ready_throttle.sv | 25 ++
 rtl/axis_frame_sink.sv | 120 ++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// ----------------------------------------------------------------------------
// conware_pkg
// Shared definitions for the conware stream blocks. It holds the frame sink
// state encoding, the bit positions inside the sink's sticky err vector, and
// the default colour words. The stream converters use the same colour words
// so that both ends of the loop decode cells in the same way.
// Ports: none (package).
// ----------------------------------------------------------------------------
package conware_pkg;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } sink_state_e;

  // err vector layout: {keep_err, color_err, missing_last, early_last}
  localparam int ERR_EARLY_LAST   = 0;
  localparam int ERR_MISSING_LAST = 1;
  localparam int ERR_COLOR        = 2;
  localparam int ERR_KEEP         = 3;

  localparam logic [31:0] COLOR_ALIVE = 32'hFFFF_FFFF;
  localparam logic [31:0] COLOR_DEAD  = 32'h0000_0000;

endpackage

// File: rtl/axis_frame_sink_if.sv
// ----------------------------------------------------------------------------
// axis_frame_sink_if
// Bundles the AXI4-Stream beat signals that flow into the frame sink.
// Signals: TVALID, TREADY, TDATA[DWIDTH], TLAST, TKEEP[4], TSTRB[4].
// Modports: master drives the beat and receives TREADY; slave is the mirror.
// ----------------------------------------------------------------------------
interface axis_frame_sink_if #(
  parameter int DWIDTH = 32
) ();
  logic              TVALID;
  logic              TREADY;
  logic [DWIDTH-1:0] TDATA;
  logic              TLAST;
  logic [3:0]        TKEEP;
  logic [3:0]        TSTRB;

  modport master (output TVALID, TDATA, TLAST, TKEEP, TSTRB, input TREADY);
  modport slave  (input TVALID, TDATA, TLAST, TKEEP, TSTRB, output TREADY);
endinterface

// File: rtl/ready_throttle.sv
// ----------------------------------------------------------------------------
// ready_throttle
// A free-running 3-bit counter walks an 8-bit pattern mask, and the selected
// bit becomes the gate. Stream sinks use it for TREADY and stream sources use
// it for TVALID throttling. A pattern of 8'hFF keeps the gate always open.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_pattern[8]   : throttle mask
//   o_gate         : i_pattern[tc]
// ----------------------------------------------------------------------------
module ready_throttle (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_pattern,
  output logic       o_gate
);
  logic [2:0] r_tc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tc <= 3'd0;
    else          r_tc <= r_tc + 3'd1;
  end

  assign o_gate = i_pattern[r_tc];
endmodule

// File: rtl/axis_frame_sink.sv
// ----------------------------------------------------------------------------
// axis_frame_sink
// AXI4-Stream slave that rebuilds each frame of colour words into a WIDTH-bit
// cell vector. It flags framing and colour errors, counts beats and frames,
// and throttles TREADY with a programmable pattern.
// Ports:
//   ACLK, ARESETN   : clock, asynchronous active-low reset
//   S_AXIS          : stream slave (TVALID/TREADY/TDATA/TLAST/TKEEP/TSTRB)
//   ready_pattern   : TREADY throttle mask (8'hFF = always ready)
//   out_data        : decoded frame, beat k at bit k
//   out_valid/ready : frame hand-off
//   err, err_clear  : sticky {keep_err, color_err, missing_last, early_last}
//   num_beats       : accepted beats, drained ones included
//   num_frames      : frames handed off
// ----------------------------------------------------------------------------
module axis_frame_sink
  import conware_pkg::*;
#(
  parameter int                DWIDTH = 32,
  parameter int                WIDTH  = 8,
  parameter logic [DWIDTH-1:0] ALIVE  = DWIDTH'(COLOR_ALIVE),
  parameter logic [DWIDTH-1:0] DEAD   = DWIDTH'(COLOR_DEAD)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  axis_frame_sink_if.slave  S_AXIS,
  input  logic [7:0]        ready_pattern,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        err,
  input  logic              err_clear,
  output logic [31:0]       num_beats,
  output logic [31:0]       num_frames
);
  localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CELL = CW'(WIDTH - 1);

  sink_state_e      r_state, w_state_nxt;
  logic [CW-1:0]    r_cell_ctr;
  logic [WIDTH-1:0] r_out_data;
  logic [3:0]       r_err, w_err_set;
  logic [31:0]      r_num_beats, r_num_frames;
  logic             w_gate, w_tready, w_accept, w_at_last, w_frame_done;

  ready_throttle u_throttle (
    .i_clk     (ACLK),
    .i_rst_n   (ARESETN),
    .i_pattern (ready_pattern),
    .o_gate    (w_gate)
  );

  // Reset is used combinationally here so that TREADY drops as soon as reset
  // asserts, without waiting for the next clock edge.
  assign w_tready      = ARESETN & w_gate & (r_state != HOLD);
  assign S_AXIS.TREADY = w_tready;
  assign w_accept      = S_AXIS.TVALID & w_tready;
  assign w_at_last     = (r_cell_ctr == LAST_CELL);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= RECV;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_err_set    = '0;
    w_frame_done = 1'b0;
    case (r_state)
      RECV: if (w_accept) begin
        if ((S_AXIS.TDATA != ALIVE) && (S_AXIS.TDATA != DEAD))
          w_err_set[ERR_COLOR] = 1'b1;
        if ((S_AXIS.TKEEP != 4'hF) || (S_AXIS.TSTRB != 4'hF))
          w_err_set[ERR_KEEP] = 1'b1;
        if (S_AXIS.TLAST) begin
          w_err_set[ERR_EARLY_LAST] = !w_at_last;
          w_state_nxt               = HOLD;
        end else if (w_at_last) begin
          w_err_set[ERR_MISSING_LAST] = 1'b1;
          w_state_nxt                 = DRAIN;
        end
      end
      DRAIN: if (w_accept && S_AXIS.TLAST) w_state_nxt = HOLD;
      HOLD: if (out_ready) begin
        w_frame_done = 1'b1;
        w_state_nxt  = RECV;
      end
      default: w_state_nxt = RECV;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cell_ctr   <= '0;
      r_out_data   <= '0;
      r_err        <= '0;
      r_num_beats  <= '0;
      r_num_frames <= '0;
    end else begin
      if (w_accept) r_num_beats <= r_num_beats + 32'd1;
      if (w_frame_done) begin
        r_num_frames <= r_num_frames + 32'd1;
        r_out_data   <= '0;
        r_cell_ctr   <= '0;
      end else if ((r_state == RECV) && w_accept) begin
        // Any word that is not ALIVE, including bad colours, stores as 0.
        r_out_data[r_cell_ctr] <= (S_AXIS.TDATA == ALIVE);
        if (!S_AXIS.TLAST && !w_at_last) r_cell_ctr <= r_cell_ctr + 1'b1;
      end
      // A new event wins over a clear arriving in the same cycle.
      r_err <= (err_clear ? 4'h0 : r_err) | w_err_set;
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = (r_state == HOLD);
  assign err        = r_err;
  assign num_beats  = r_num_beats;
  assign num_frames = r_num_frames;
endmodule
